alu_multicycle: RTL and testbench

//  Execute stage downstream of the ALU-control decoder. Consumes its 4-bit alu_ctrl code plus two XLEN operands.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_logic_comb.sv | 27 ++
 rtl/alu_multicycle.sv | 136 +++++++++++++
 tb/tb_alu_multicycle.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, FSM states and default width
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_kind_e;

    function automatic logic is_shift_op(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_logic_comb.sv
// rtl/alu_logic_comb.sv - single-cycle ADD/SUB/AND/OR/XOR/SLT/SLTU datapath
module alu_logic_comb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      ctrl_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o
);

    always_comb begin
        y_o = a_i + b_i;
        case (ctrl_i)
            ALU_SUB:  y_o = a_i - b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            // unused and shift codes fall through to ADD
            default:  y_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with 1-bit/cycle serial shifter and valid/ready result
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    shift_kind_e     kind_q, kind_d;
    logic            sign_q, sign_d;

    logic [XLEN-1:0] logic_y;
    logic [SHW-1:0]  shamt;
    logic            in_is_shift;
    shift_kind_e     in_kind;
    logic [XLEN-1:0] work_first;
    logic [XLEN-1:0] work_next;

    function automatic logic [XLEN-1:0] shift1(input shift_kind_e k, input logic s,
                                               input logic [XLEN-1:0] w);
        case (k)
            SH_SLL:  return {w[XLEN-2:0], 1'b0};
            SH_SRA:  return {s, w[XLEN-1:1]};
            default: return {1'b0, w[XLEN-1:1]};
        endcase
    endfunction

    alu_logic_comb #(.XLEN(XLEN)) u_logic (
        .ctrl_i (alu_ctrl),
        .a_i    (op_a),
        .b_i    (op_b),
        .y_o    (logic_y)
    );

    assign shamt       = op_b[SHW-1:0];
    assign in_is_shift = is_shift_op(alu_ctrl);
    assign in_kind     = (alu_ctrl == ALU_SLL) ? SH_SLL :
                         (alu_ctrl == ALU_SRA) ? SH_SRA : SH_SRL;
    // First bit is shifted on the accept edge so a shift by N is visible N cycles after accept.
    assign work_first  = shift1(in_kind, op_a[XLEN-1], op_a);
    assign work_next   = shift1(kind_q, sign_q, work_q);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        sign_d   = sign_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!in_is_shift) begin
                        result_d = logic_y;
                        state_d  = ST_DONE;
                    end else if (shamt == '0) begin
                        result_d = op_a;
                        state_d  = ST_DONE;
                    end else if (shamt == SHW'(1)) begin
                        result_d = work_first;
                        state_d  = ST_DONE;
                    end else begin
                        work_d  = work_first;
                        cnt_d   = shamt - SHW'(1);
                        kind_d  = in_kind;
                        sign_d  = op_a[XLEN-1];
                        state_d = ST_SHIFT;
                    end
                    zero_d = (result_d == '0);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    result_d = work_next;
                    zero_d   = (work_next == '0);
                    state_d  = ST_DONE;
                end else begin
                    work_d = work_next;
                    cnt_d  = cnt_q - SHW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            work_q   <= '0;
            cnt_q    <= '0;
            kind_q   <= SH_SLL;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
            sign_q   <= sign_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed and randomized checks of alu_multicycle against a behavioural model
module tb_alu_multicycle;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.XLEN(XLEN), .SHW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    function automatic logic [31:0] model_result(input logic [3:0] c, input logic [31:0] a,
                                                 input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a << sh;
            4'd7: return a >> sh;
            4'd8: return $unsigned($signed(a) >>> sh);
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] c, input logic [31:0] b);
        if ((c == 4'd6 || c == 4'd7 || c == 4'd8) && (b % 32) != 0)
            return int'(b % 32);
        return 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input bit poke);
        int lat;
        int guard;
        logic [31:0] exp_r;
        int exp_l;
        logic [31:0] held_r;
        logic held_z;
        exp_r = model_result(c, a, b);
        exp_l = model_latency(c, b);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_op", in_ready, 1);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < XLEN + 4) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", c), lat, exp_l);
        check($sformatf("result op%0d a=%h b=%h", c, a, b), result, exp_r);
        check($sformatf("zero op%0d", c), zero, (exp_r == 0));
        check("in_ready_in_done", in_ready, 0);
        check("busy_in_done", busy, 1);
        held_r = result;
        held_z = zero;
        for (int i = 0; i < stall; i++) begin
            in_valid = poke;
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_result_stable", result, held_r);
            check("stall_zero_stable", zero, held_z);
            check("stall_in_ready_low", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_take", out_valid, 0);
        check("in_ready_after_take", in_ready, 1);
    endtask

    initial begin
        bit seen_valid;
        logic [3:0] rc;
        logic [31:0] ra;
        logic [31:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 4'd0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_zero", zero, 0);
        check("reset_busy", busy, 0);

        run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b0);
        run_op(4'd1, 32'h0000_1234, 32'h0000_1234, 0, 1'b0);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run_op(4'd8, 32'h8000_0000, 32'd31, 0, 1'b0);
        run_op(4'd6, 32'hCAFE_0001, 32'h0000_0020, 0, 1'b0);
        run_op(4'd7, 32'h8000_0001, 32'd1, 0, 1'b0);
        run_op(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5, 1'b1);

        // abandon an SRL partway through with reset
        alu_ctrl = 4'd7;
        op_a     = 32'h0000_00F0;
        op_b     = 32'd8;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_shift_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_zero", zero, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_out_valid", seen_valid, 0);
        run_op(4'd0, 32'd2, 32'd3, 0, 1'b0);

        // reset wins over a simultaneous accept
        alu_ctrl = 4'd0;
        op_a     = 32'd1;
        op_b     = 32'd1;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_prio_in_ready", in_ready, 1);
        check("rst_prio_busy", busy, 0);
        @(negedge clk);
        check("rst_prio_out_valid", out_valid, 0);

        run_op(4'd15, 32'd3, 32'd4, 0, 1'b0);
        run_op(4'd10, 32'hFFFF_FFFF, 32'd1, 1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            rc = 4'($urandom_range(0, 9));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            if ($urandom_range(0, 4) == 0) ra = {$urandom_range(0, 1) == 1, 31'd0};
            run_op(rc, ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
